// File: rtl/ysyx_23060201_wbu.sv
// Write-back stage: accepts one completed instruction, waits for load data if needed,
// aligns/extends it and drives the register-file write port for one cycle.
// Optional retire counter enabled by defining YSYX_23060201_WBU_RETIRE_CNT_EN.
module ysyx_23060201_wbu #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_rd_wen,
  input  logic [1:0]                in_sel,
  input  logic [DATA_WIDTH-1:0]     in_alu_res,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_csr_rdata,
  input  logic [2:0]                in_ld_type,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic                      commit_valid,
  output logic [DATA_WIDTH-1:0]     commit_pc,
  output logic                      ld_misalign,
  output logic [63:0]               retire_cnt
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_CSR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_e;

  // Byte/halfword lane select plus extension; reserved funct3 codes read the whole word.
  function automatic logic [DATA_WIDTH-1:0] align_load(
    input logic [2:0]            ld_type,
    input logic [1:0]            a,
    input logic [DATA_WIDTH-1:0] word
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (ld_type)
      3'b000:  r = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  r = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic load_misaligned(input logic [2:0] ld_type, input logic [1:0] a);
    logic m;
    case (ld_type)
      3'b000, 3'b100: m = 1'b0;
      3'b001, 3'b101: m = a[0];
      default:        m = (a != 2'b00);
    endcase
    return m;
  endfunction

  state_e                    state_q, state_d;
  logic [GPR_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      rd_wen_q, rd_wen_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d;
  logic [2:0]                ld_type_q, ld_type_d;
  logic [1:0]                addr_lo_q, addr_lo_d;

  logic                      in_ready_q, in_ready_d;
  logic                      gpr_wen_q, gpr_wen_d;
  logic [GPR_ADDR_WIDTH-1:0] gpr_waddr_q, gpr_waddr_d;
  logic [DATA_WIDTH-1:0]     gpr_wdata_q, gpr_wdata_d;
  logic                      commit_valid_q, commit_valid_d;
  logic [DATA_WIDTH-1:0]     commit_pc_q, commit_pc_d;
  logic                      ld_misalign_q, ld_misalign_d;

  logic [DATA_WIDTH-1:0]     result_s;
  logic [DATA_WIDTH-1:0]     load_res_s;
  logic                      mis_s;

  // Outputs are registered: the commit values are computed on the transition into COMMIT.
  always_comb begin
    state_d        = state_q;
    rd_d           = rd_q;
    rd_wen_d       = rd_wen_q;
    pc_d           = pc_q;
    ld_type_d      = ld_type_q;
    addr_lo_d      = addr_lo_q;
    gpr_wen_d      = 1'b0;
    gpr_waddr_d    = gpr_waddr_q;
    gpr_wdata_d    = gpr_wdata_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    ld_misalign_d  = 1'b0;
    result_s       = in_alu_res;
    load_res_s     = align_load(ld_type_q, addr_lo_q, mem_rdata);
    mis_s          = load_misaligned(ld_type_q, addr_lo_q);

    case (in_sel)
      SEL_ALU:  result_s = in_alu_res;
      SEL_PC4:  result_s = in_pc + DATA_WIDTH'(4);
      SEL_CSR:  result_s = in_csr_rdata;
      default:  result_s = in_alu_res;
    endcase

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rd_d      = in_rd;
          rd_wen_d  = in_rd_wen;
          pc_d      = in_pc;
          ld_type_d = in_ld_type;
          addr_lo_d = in_alu_res[1:0];
          if (in_sel == SEL_LOAD) begin
            state_d = S_WAIT_MEM;
          end else begin
            state_d        = S_COMMIT;
            gpr_wen_d      = in_rd_wen && (in_rd != {GPR_ADDR_WIDTH{1'b0}});
            gpr_waddr_d    = in_rd;
            gpr_wdata_d    = result_s;
            commit_valid_d = 1'b1;
            commit_pc_d    = in_pc;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d        = S_COMMIT;
          gpr_wen_d      = rd_wen_q && (rd_q != {GPR_ADDR_WIDTH{1'b0}}) && !mis_s;
          gpr_waddr_d    = rd_q;
          gpr_wdata_d    = load_res_s;
          commit_valid_d = 1'b1;
          commit_pc_d    = pc_q;
          ld_misalign_d  = mis_s;
        end else begin
          state_d = S_WAIT_MEM;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  // State, captured instruction fields and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rd_q           <= {GPR_ADDR_WIDTH{1'b0}};
      rd_wen_q       <= 1'b0;
      pc_q           <= {DATA_WIDTH{1'b0}};
      ld_type_q      <= 3'b000;
      addr_lo_q      <= 2'b00;
      in_ready_q     <= 1'b1;
      gpr_wen_q      <= 1'b0;
      gpr_waddr_q    <= {GPR_ADDR_WIDTH{1'b0}};
      gpr_wdata_q    <= {DATA_WIDTH{1'b0}};
      commit_valid_q <= 1'b0;
      commit_pc_q    <= {DATA_WIDTH{1'b0}};
      ld_misalign_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      rd_wen_q       <= rd_wen_d;
      pc_q           <= pc_d;
      ld_type_q      <= ld_type_d;
      addr_lo_q      <= addr_lo_d;
      in_ready_q     <= in_ready_d;
      gpr_wen_q      <= gpr_wen_d;
      gpr_waddr_q    <= gpr_waddr_d;
      gpr_wdata_q    <= gpr_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      ld_misalign_q  <= ld_misalign_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign gpr_wen      = gpr_wen_q;
  assign gpr_waddr    = gpr_waddr_q;
  assign gpr_wdata    = gpr_wdata_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign ld_misalign  = ld_misalign_q;

`ifdef YSYX_23060201_WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // Counts every retire pulse, misaligned loads included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_q <= 64'd0;
    end else if (commit_valid_q) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end else begin
      retire_cnt_q <= retire_cnt_q;
    end
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_23060201_wbu.sv
// Self-checking bench for ysyx_23060201_wbu: directed table, hand sequences for
// reset/backpressure corners, and randomized transactions against a behavioural model.
module tb_ysyx_23060201_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [1:0]  in_sel;
  logic [31:0] in_alu_res;
  logic [31:0] in_pc;
  logic [31:0] in_csr_rdata;
  logic [2:0]  in_ld_type;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        ld_misalign;
  logic [63:0] retire_cnt;

  ysyx_23060201_wbu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_sel(in_sel),
    .in_alu_res(in_alu_res), .in_pc(in_pc), .in_csr_rdata(in_csr_rdata),
    .in_ld_type(in_ld_type),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .ld_misalign(ld_misalign), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint unsigned ncommit = 0;

  typedef struct {
    string       nm;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] csr;
    logic [2:0]  ldt;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] e_data;
    logic        e_wen;
    logic        e_mis;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input string nm, input logic [4:0] rd, input logic wen,
                              input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                              input logic [31:0] csr, input logic [2:0] ldt, input logic [31:0] rdata,
                              input int lat, input logic [31:0] e_data, input logic e_wen,
                              input logic e_mis);
    vec_t v;
    v.nm = nm; v.rd = rd; v.wen = wen; v.sel = sel; v.alu = alu; v.pc = pc; v.csr = csr;
    v.ldt = ldt; v.rdata = rdata; v.lat = lat; v.e_data = e_data; v.e_wen = e_wen; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt();
`ifdef YSYX_23060201_WBU_RETIRE_CNT_EN
    return ncommit;
`else
    return 64'd0;
`endif
  endfunction

  // Reference model: result selection and load extraction from plain arithmetic.
  task automatic ref_model(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] csr,
                           input logic [2:0] ldt, input logic [31:0] rdata,
                           output logic [31:0] data, output logic e_wen, output logic e_mis);
    longint unsigned a, bt, hw, w;
    a  = alu % 4;
    w  = rdata;
    bt = (w / (longint'(1) << (8 * a))) % 256;
    hw = (w / (longint'(1) << (16 * (a / 2)))) % 65536;
    e_mis = 1'b0;
    case (sel)
      2'd0: data = alu;
      2'd2: data = 32'((longint'(pc) + 4) % (longint'(1) << 32));
      2'd3: data = csr;
      default: begin
        if (ldt == 3'd0)      data = (bt >= 128) ? 32'(bt + 64'hFFFFFF00) : 32'(bt);
        else if (ldt == 3'd4) data = 32'(bt);
        else if (ldt == 3'd1) data = (hw >= 32768) ? 32'(hw + 64'hFFFF0000) : 32'(hw);
        else if (ldt == 3'd5) data = 32'(hw);
        else                  data = rdata;
        if (ldt == 3'd1 || ldt == 3'd5)      e_mis = (a % 2) != 0;
        else if (ldt == 3'd0 || ldt == 3'd4) e_mis = 1'b0;
        else                                 e_mis = (a != 0);
      end
    endcase
    e_wen = wen && (rd != 5'd0) && !e_mis;
  endtask

  task automatic run_txn(input string nm, input logic [4:0] rd, input logic wen,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] csr, input logic [2:0] ldt, input logic [31:0] rdata,
                         input int lat, input logic [31:0] e_data, input logic e_wen,
                         input logic e_mis);
    chk({nm, ".ready_idle"}, 64'(in_ready), 64'd1);
    in_rd = rd; in_rd_wen = wen; in_sel = sel; in_alu_res = alu; in_pc = pc;
    in_csr_rdata = csr; in_ld_type = ldt; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (sel == 2'b01) begin
      chk({nm, ".ready_wait"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < lat; i++) begin
        step();
        chk({nm, ".no_commit_wait"}, 64'(commit_valid), 64'd0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    chk({nm, ".commit_valid"}, 64'(commit_valid), 64'd1);
    chk({nm, ".gpr_wen"}, 64'(gpr_wen), 64'(e_wen));
    chk({nm, ".gpr_waddr"}, 64'(gpr_waddr), 64'(rd));
    chk({nm, ".gpr_wdata"}, 64'(gpr_wdata), 64'(e_data));
    chk({nm, ".ld_misalign"}, 64'(ld_misalign), 64'(e_mis));
    chk({nm, ".commit_pc"}, 64'(commit_pc), 64'(pc));
    chk({nm, ".ready_commit"}, 64'(in_ready), 64'd0);
    ncommit++;
    step();
    chk({nm, ".commit_drop"}, 64'(commit_valid), 64'd0);
    chk({nm, ".wen_drop"}, 64'(gpr_wen), 64'd0);
    chk({nm, ".mis_drop"}, 64'(ld_misalign), 64'd0);
    chk({nm, ".ready_back"}, 64'(in_ready), 64'd1);
    chk({nm, ".waddr_hold"}, 64'(gpr_waddr), 64'(rd));
    chk({nm, ".wdata_hold"}, 64'(gpr_wdata), 64'(e_data));
    chk({nm, ".retire_cnt"}, retire_cnt, exp_cnt());
  endtask

  initial begin
    logic [31:0] d;
    logic        ew, em;
    logic [4:0]  r_rd;
    logic        r_wen;
    logic [1:0]  r_sel;
    logic [31:0] r_alu, r_pc, r_csr, r_rdata;
    logic [2:0]  r_ldt;

    tbl[0]  = mk("alu_rd5",  5'd5,  1'b1, 2'b00, 32'h12345678, 32'h00001000, 32'h0, 3'd0, 32'h0, 0, 32'h12345678, 1'b1, 1'b0);
    tbl[1]  = mk("jal_wrap", 5'd1,  1'b1, 2'b10, 32'h0, 32'hFFFFFFFC, 32'h0, 3'd0, 32'h0, 0, 32'h00000000, 1'b1, 1'b0);
    tbl[2]  = mk("jal",      5'd1,  1'b1, 2'b10, 32'h0, 32'h80000000, 32'h0, 3'd0, 32'h0, 0, 32'h80000004, 1'b1, 1'b0);
    tbl[3]  = mk("lb_a3",    5'd10, 1'b1, 2'b01, 32'h00001003, 32'h00002000, 32'h0, 3'd0, 32'h80FF7F01, 3, 32'hFFFFFF80, 1'b1, 1'b0);
    tbl[4]  = mk("lhu_a2",   5'd11, 1'b1, 2'b01, 32'h00001002, 32'h00002004, 32'h0, 3'd5, 32'h80FF7F01, 1, 32'h000080FF, 1'b1, 1'b0);
    tbl[5]  = mk("lw_mis",   5'd12, 1'b1, 2'b01, 32'h00001002, 32'h00002008, 32'h0, 3'd2, 32'h80FF7F01, 2, 32'h80FF7F01, 1'b0, 1'b1);
    tbl[6]  = mk("alu_rd0",  5'd0,  1'b1, 2'b00, 32'hAAAA5555, 32'h0000200C, 32'h0, 3'd0, 32'h0, 0, 32'hAAAA5555, 1'b0, 1'b0);
    tbl[7]  = mk("csr",      5'd7,  1'b1, 2'b11, 32'h11111111, 32'h00002010, 32'hDEADBEEF, 3'd0, 32'h0, 0, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[8]  = mk("lh_mis",   5'd8,  1'b1, 2'b01, 32'h00001001, 32'h00002014, 32'h0, 3'd1, 32'h80FF7F01, 0, 32'h00007F01, 1'b0, 1'b1);
    tbl[9]  = mk("lb_a0",    5'd9,  1'b1, 2'b01, 32'h00001000, 32'h00002018, 32'h0, 3'd0, 32'h80FF7F01, 0, 32'h00000001, 1'b1, 1'b0);
    tbl[10] = mk("lh_a2",    5'd13, 1'b1, 2'b01, 32'h00001002, 32'h0000201C, 32'h0, 3'd1, 32'h80FF7F01, 1, 32'hFFFF80FF, 1'b1, 1'b0);
    tbl[11] = mk("lbu_a3",   5'd14, 1'b1, 2'b01, 32'h00001003, 32'h00002020, 32'h0, 3'd4, 32'h80FF7F01, 0, 32'h00000080, 1'b1, 1'b0);
    tbl[12] = mk("lw_ok",    5'd15, 1'b1, 2'b01, 32'h00001004, 32'h00002024, 32'h0, 3'd2, 32'h80FF7F01, 2, 32'h80FF7F01, 1'b1, 1'b0);
    tbl[13] = mk("no_wen",   5'd3,  1'b0, 2'b00, 32'h00000005, 32'h00002028, 32'h0, 3'd0, 32'h0, 0, 32'h00000005, 1'b0, 1'b0);
    tbl[14] = mk("ld_rsv6",  5'd16, 1'b1, 2'b01, 32'h00001000, 32'h0000202C, 32'h0, 3'd6, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b1, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_rd_wen = 1'b0; in_sel = 2'b00;
    in_alu_res = 32'd0; in_pc = 32'd0; in_csr_rdata = 32'd0; in_ld_type = 3'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    step(); step();
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.gpr_wen", 64'(gpr_wen), 64'd0);
    chk("rst.gpr_waddr", 64'(gpr_waddr), 64'd0);
    chk("rst.gpr_wdata", 64'(gpr_wdata), 64'd0);
    chk("rst.commit_valid", 64'(commit_valid), 64'd0);
    chk("rst.commit_pc", 64'(commit_pc), 64'd0);
    chk("rst.ld_misalign", 64'(ld_misalign), 64'd0);
    chk("rst.retire_cnt", retire_cnt, 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      run_txn(tbl[i].nm, tbl[i].rd, tbl[i].wen, tbl[i].sel, tbl[i].alu, tbl[i].pc, tbl[i].csr,
              tbl[i].ldt, tbl[i].rdata, tbl[i].lat, tbl[i].e_data, tbl[i].e_wen, tbl[i].e_mis);
    end

    // mem_rvalid while idle must be ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    step();
    chk("idle_rvalid.commit", 64'(commit_valid), 64'd0);
    chk("idle_rvalid.ready", 64'(in_ready), 64'd1);
    step();
    mem_rvalid = 1'b0;
    chk("idle_rvalid.wen", 64'(gpr_wen), 64'd0);

    // in_valid held through WAIT_MEM: the second instruction waits for IDLE
    in_rd = 5'd20; in_rd_wen = 1'b1; in_sel = 2'b01; in_alu_res = 32'h00003000;
    in_pc = 32'h00004000; in_ld_type = 3'd2; in_valid = 1'b1;
    step();
    in_rd = 5'd21; in_sel = 2'b00; in_alu_res = 32'h0BADF00D; in_pc = 32'h00004004;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.ready_wait", 64'(in_ready), 64'd0);
      chk("hold.no_commit", 64'(commit_valid), 64'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h01020304;
    step();
    mem_rvalid = 1'b0;
    chk("hold.ld_commit", 64'(commit_valid), 64'd1);
    chk("hold.ld_waddr", 64'(gpr_waddr), 64'd20);
    chk("hold.ld_wdata", 64'(gpr_wdata), 64'h01020304);
    chk("hold.ld_pc", 64'(commit_pc), 64'h00004000);
    ncommit++;
    step();
    chk("hold.idle_ready", 64'(in_ready), 64'd1);
    chk("hold.idle_nocommit", 64'(commit_valid), 64'd0);
    step();
    in_valid = 1'b0;
    chk("hold.alu_commit", 64'(commit_valid), 64'd1);
    chk("hold.alu_waddr", 64'(gpr_waddr), 64'd21);
    chk("hold.alu_wdata", 64'(gpr_wdata), 64'h0BADF00D);
    chk("hold.alu_pc", 64'(commit_pc), 64'h00004004);
    ncommit++;
    step();
    chk("hold.retire_cnt", retire_cnt, exp_cnt());

    // reset during WAIT_MEM discards the load; stale response is ignored
    in_rd = 5'd22; in_rd_wen = 1'b1; in_sel = 2'b01; in_alu_res = 32'h0;
    in_pc = 32'h00005000; in_ld_type = 3'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #2;
    ncommit = 0;
    chk("rstwait.ready", 64'(in_ready), 64'd1);
    chk("rstwait.waddr", 64'(gpr_waddr), 64'd0);
    chk("rstwait.cnt", retire_cnt, 64'd0);
    rst = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_rvalid = 1'b0;
    chk("rstwait.no_commit", 64'(commit_valid), 64'd0);
    chk("rstwait.no_wen", 64'(gpr_wen), 64'd0);
    chk("rstwait.ready2", 64'(in_ready), 64'd1);

    // reset during COMMIT cuts the retire pulse
    in_rd = 5'd23; in_rd_wen = 1'b1; in_sel = 2'b00; in_alu_res = 32'h77;
    in_pc = 32'h00006000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("rstcommit.no_commit", 64'(commit_valid), 64'd0);
    chk("rstcommit.no_wen", 64'(gpr_wen), 64'd0);
    rst = 1'b0;
    step();
    chk("rstcommit.ready", 64'(in_ready), 64'd1);
    chk("rstcommit.cnt", retire_cnt, 64'd0);

    // randomized transactions against the reference model
    for (int n = 0; n < 200; n++) begin
      r_rd    = 5'($urandom_range(0, 31));
      r_wen   = 1'($urandom_range(0, 3) != 0);
      r_sel   = 2'($urandom_range(0, 3));
      r_alu   = $urandom;
      r_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      r_csr   = $urandom;
      r_ldt   = 3'($urandom_range(0, 7));
      r_rdata = $urandom;
      ref_model(r_rd, r_wen, r_sel, r_alu, r_pc, r_csr, r_ldt, r_rdata, d, ew, em);
      run_txn("rand", r_rd, r_wen, r_sel, r_alu, r_pc, r_csr, r_ldt, r_rdata,
              $urandom_range(0, 3), d, ew, em);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
